com_multichannel: RTL
=====================

// Module: com_multichannel
// PURPOSE
//  Per-frame centre-of-mass engine for NUM_CH independent pixel masks. It sits after the
//  mask stage in the camera pipeline and replaces the single-channel centroid block.
//  Per frame it accumulates x/y sums and pixel counts for each channel. On tabulate_in it
//  snapshots the totals, then divides them with a shared multi-cycle divider and publishes
//  per-channel centroids with a found flag.
// PARAMETERS
//  NUM_CH     2   number of mask channels (>=1)
//  X_W        11  x coordinate width
//  Y_W        10  y coordinate width
//  CNT_W      21  pixel counter width; SUM_W = X_W+CNT_W (x sum), Y_W+CNT_W (y sum)
//  MIN_PIXELS 16  minimum count for a channel result to be valid (>=1)
// PORTS
//  clk_in       in   1           system clock
//  rst_in       in   1           asynchronous, active-low reset
//  x_in         in   X_W         pixel x coordinate
//  y_in         in   Y_W         pixel y coordinate
//  valid_in     in   NUM_CH      bit c: pixel belongs to channel c's mask
//  tabulate_in  in   1           frame-end strobe (1 cycle)
//  x_com        out  NUM_CH*X_W  channel c at [c*X_W +: X_W], floor(sum_x/count)
//  y_com        out  NUM_CH*Y_W  channel c at [c*Y_W +: Y_W], floor(sum_y/count)
//  found        out  NUM_CH      bit c: channel c count >= MIN_PIXELS in last result
//  valid_com    out  1           1-cycle pulse: x_com/y_com/found updated
//  busy         out  1           divider running
//  overrun      out  1           1-cycle pulse: tabulate_in arrived while busy
// BEHAVIOUR
//  - Reset (rst_in=0, async): all accumulators, x_com, y_com, found, valid_com, busy and
//    overrun go to 0. FSM goes to IDLE. A division in progress is abandoned.
//  - Accumulate: each cycle, every channel c with valid_in[c]=1 adds x_in/y_in to sums and
//    increments its count. Count saturates at 2^CNT_W-1. After saturation the sums freeze
//    and the channel is reported found=0.
//  - A pixel with valid_in in the same cycle as tabulate_in belongs to the ending frame.
//    It is included in the snapshot. Accumulators restart at 0 on the next cycle.
//  - FSM IDLE: on tabulate_in, latch all channel totals into snapshot registers, clear the
//    accumulators, go to LOAD with ch=0, busy=1.
//  - LOAD (1 cycle): load the divider with the snapshot for channel ch. Go to DIV.
//  - DIV: restoring divide, 1 quotient bit per cycle, for X_W+CNT_W cycles. x and y run
//    in parallel; y is zero-extended to the x dividend width.
//  - After DIV, if ch<NUM_CH-1: ch++ and go to LOAD. Else go to DONE.
//  - DONE (1 cycle): update all outputs at once, pulse valid_com, busy=0, go to IDLE.
//  - Latency: valid_com is high exactly NUM_CH*(X_W+CNT_W+1)+1 cycles after the cycle in
//    which tabulate_in was sampled.
//  - Per-channel result:
//    - count >= MIN_PIXELS and not saturated: x_com/y_com = truncated quotient (low
//      X_W/Y_W bits), found=1.
//    - otherwise: x_com/y_com hold their previous values, found=0. No divide-by-zero.
//  - tabulate_in while busy (LOAD/DIV/DONE):
//    - the new frame totals are discarded and the accumulators are cleared;
//    - overrun pulses the next cycle;
//    - the division in progress completes normally.
//  - valid_com and overrun are never high for more than 1 cycle per event.
//  - Outputs only change in DONE or on reset.
// TESTING
//  1 MIN_PIXELS=4, ch0 pixels (10,20),(12,20),(10,22),(12,22), tabulate ->
//    x_com0=11, y_com0=21, found[0]=1, valid_com at the exact latency.
//  2 MIN_PIXELS=1, ch0 pixels (0,0),(1,0),(1,0) -> x_com0=0 (floor 2/3), y_com0=0, found=1.
//  3 ch1 gets 3 pixels with MIN_PIXELS=4 after a frame that gave (100,50) ->
//    found[1]=0, x_com1/y_com1 stay 100/50.
//  4 NUM_CH=2, same cycle valid_in=2'b11 at (640,360), plus ch1-only (0,0) ->
//    ch0=(640,360), ch1=(320,180).
//  5 Second tabulate 5 cycles after the first -> overrun pulse, first result delivered,
//    no second valid_com, next frame starts from 0 counts.
//  6 rst_in low mid-DIV -> all outputs 0 immediately, no valid_com, IDLE after release.

Source files
------------

// File: rtl/com_multichannel.sv
// Multi-channel centre-of-mass engine: per-frame x/y sums and pixel counts per mask channel,
// snapshotted on frame end and divided by one shared restoring divider.
module com_multichannel #(
    parameter int NUM_CH     = 2,
    parameter int X_W        = 11,
    parameter int Y_W        = 10,
    parameter int CNT_W      = 21,
    parameter int MIN_PIXELS = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [X_W-1:0]        x_in,
    input  logic [Y_W-1:0]        y_in,
    input  logic [NUM_CH-1:0]     valid_in,
    input  logic                  tabulate_in,
    output logic [NUM_CH*X_W-1:0] x_com,
    output logic [NUM_CH*Y_W-1:0] y_com,
    output logic [NUM_CH-1:0]     found,
    output logic                  valid_com,
    output logic                  busy,
    output logic                  overrun
);

    localparam int SX_W = X_W + CNT_W;
    localparam int SY_W = Y_W + CNT_W;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BC_W = $clog2(SX_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_PIXELS);
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(SX_W - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;
    state_t state_reg, state_next;

    logic [SX_W-1:0]  acc_x_reg    [NUM_CH];
    logic [SY_W-1:0]  acc_y_reg    [NUM_CH];
    logic [CNT_W-1:0] acc_cnt_reg  [NUM_CH];
    logic [SX_W-1:0]  tot_x        [NUM_CH];
    logic [SY_W-1:0]  tot_y        [NUM_CH];
    logic [CNT_W-1:0] tot_cnt      [NUM_CH];
    logic [SX_W-1:0]  snap_x_reg   [NUM_CH];
    logic [SY_W-1:0]  snap_y_reg   [NUM_CH];
    logic [CNT_W-1:0] snap_cnt_reg [NUM_CH];
    logic [X_W-1:0]   res_x_reg    [NUM_CH];
    logic [Y_W-1:0]   res_y_reg    [NUM_CH];
    logic [NUM_CH-1:0] take;

    logic [CH_W-1:0]  ch_reg;
    logic [BC_W-1:0]  bit_reg;
    logic [SX_W-1:0]  quo_x_reg, quo_y_reg, quo_x_next, quo_y_next;
    logic [CNT_W-1:0] rem_x_reg, rem_y_reg, rem_x_next, rem_y_next, div_reg;
    logic [CNT_W:0]   shift_x, shift_y;

    // Running totals including this cycle's pixel; a saturated channel stops accumulating.
    always_comb begin
        take = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            take[c]    = valid_in[c] && (acc_cnt_reg[c] != CNT_MAX);
            tot_x[c]   = acc_x_reg[c] + (take[c] ? SX_W'(x_in) : '0);
            tot_y[c]   = acc_y_reg[c] + (take[c] ? SY_W'(y_in) : '0);
            tot_cnt[c] = acc_cnt_reg[c] + (take[c] ? CNT_W'(1) : '0);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_x_reg[c]    <= '0;
                acc_y_reg[c]    <= '0;
                acc_cnt_reg[c]  <= '0;
                snap_x_reg[c]   <= '0;
                snap_y_reg[c]   <= '0;
                snap_cnt_reg[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                // Frame end always restarts the accumulators, even when the frame is dropped.
                acc_x_reg[c]   <= tabulate_in ? '0 : tot_x[c];
                acc_y_reg[c]   <= tabulate_in ? '0 : tot_y[c];
                acc_cnt_reg[c] <= tabulate_in ? '0 : tot_cnt[c];
                if (tabulate_in && state_reg == IDLE) begin
                    snap_x_reg[c]   <= tot_x[c];
                    snap_y_reg[c]   <= tot_y[c];
                    snap_cnt_reg[c] <= tot_cnt[c];
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (tabulate_in) state_next = LOAD;
            LOAD: state_next = DIV;
            DIV:  if (bit_reg == LAST_BIT) state_next = (ch_reg == LAST_CH) ? DONE : LOAD;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg != IDLE);

    // One restoring-division step for x and y against the shared divisor.
    always_comb begin
        shift_x = {rem_x_reg, quo_x_reg[SX_W-1]};
        shift_y = {rem_y_reg, quo_y_reg[SX_W-1]};
        if (shift_x >= {1'b0, div_reg}) begin
            rem_x_next = CNT_W'(shift_x - {1'b0, div_reg});
            quo_x_next = {quo_x_reg[SX_W-2:0], 1'b1};
        end else begin
            rem_x_next = shift_x[CNT_W-1:0];
            quo_x_next = {quo_x_reg[SX_W-2:0], 1'b0};
        end
        if (shift_y >= {1'b0, div_reg}) begin
            rem_y_next = CNT_W'(shift_y - {1'b0, div_reg});
            quo_y_next = {quo_y_reg[SX_W-2:0], 1'b1};
        end else begin
            rem_y_next = shift_y[CNT_W-1:0];
            quo_y_next = {quo_y_reg[SX_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ch_reg    <= '0;
            bit_reg   <= '0;
            quo_x_reg <= '0;
            quo_y_reg <= '0;
            rem_x_reg <= '0;
            rem_y_reg <= '0;
            div_reg   <= '0;
            x_com     <= '0;
            y_com     <= '0;
            found     <= '0;
            valid_com <= 1'b0;
            overrun   <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                res_x_reg[c] <= '0;
                res_y_reg[c] <= '0;
            end
        end else begin
            valid_com <= 1'b0;
            overrun   <= tabulate_in && (state_reg != IDLE);
            case (state_reg)
                IDLE: ch_reg <= '0;
                LOAD: begin
                    quo_x_reg <= snap_x_reg[ch_reg];
                    quo_y_reg <= SX_W'(snap_y_reg[ch_reg]);
                    rem_x_reg <= '0;
                    rem_y_reg <= '0;
                    div_reg   <= snap_cnt_reg[ch_reg];
                    bit_reg   <= '0;
                end
                DIV: begin
                    quo_x_reg <= quo_x_next;
                    quo_y_reg <= quo_y_next;
                    rem_x_reg <= rem_x_next;
                    rem_y_reg <= rem_y_next;
                    bit_reg   <= bit_reg + BC_W'(1);
                    if (bit_reg == LAST_BIT) begin
                        res_x_reg[ch_reg] <= quo_x_next[X_W-1:0];
                        res_y_reg[ch_reg] <= quo_y_next[Y_W-1:0];
                        if (ch_reg != LAST_CH) ch_reg <= ch_reg + CH_W'(1);
                    end
                end
                DONE: begin
                    valid_com <= 1'b1;
                    for (int c = 0; c < NUM_CH; c++) begin
                        // Too few or saturated pixels: keep the previous centroid, report not found.
                        if (snap_cnt_reg[c] >= CNT_MIN && snap_cnt_reg[c] != CNT_MAX) begin
                            x_com[c*X_W +: X_W] <= res_x_reg[c];
                            y_com[c*Y_W +: Y_W] <= res_y_reg[c];
                            found[c]            <= 1'b1;
                        end else begin
                            found[c] <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
